// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage and its hold register.
//   IMEM_ADDR_W      : instruction-memory word-address width
//   INSTR_W          : instruction width
//   NOP_INSTR        : value driven on if_instr when nothing is valid
//   RESET_PC_DEFAULT : default program counter after reset
package fetch_pkg;
  localparam int unsigned          IMEM_ADDR_W      = 10;
  localparam int unsigned          INSTR_W          = 32;
  localparam logic [INSTR_W-1:0]   NOP_INSTR        = 32'h0;
  localparam logic [IMEM_ADDR_W-1:0] RESET_PC_DEFAULT = '0;
endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry parking register for an instruction that decode could not take.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   capture         : load instr_in/pc_in and mark valid
//   clear           : drop the parked entry (ignored when capture is high)
//   instr_in, pc_in : instruction and its word address to park
//   valid, instr, pc: parked entry
module fetch_hold_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              clear,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= DATA_W'(NOP_INSTR);
      pc    <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Program counter and fetch control in front of a 1-cycle synchronous
// instruction memory. Pairs each returned word with its PC and presents a
// valid/stall stream to decode; a stalled instruction is parked so the
// memory's read latency never loses or duplicates anything.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   fetch_en               : allow new fetches
//   redirect_valid/_pc     : taken branch/jump and its target word address
//   imem_addr / imem_rdata : memory address (sampled at posedge) / data (next cycle)
//   id_stall               : decode cannot accept the current instruction
//   if_valid/if_instr/if_pc: instruction stream to decode (zeroed when invalid)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned       DATA_W   = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_valid_q;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_instr;
  logic [ADDR_W-1:0] hold_pc;
  logic              out_valid;
  logic              issue;
  logic              hold_capture;
  logic              hold_clear;

  assign out_valid = hold_valid | req_valid_q;
  // A stalled live instruction blocks new issue; a redirect always issues.
  assign issue     = redirect_valid | (fetch_en & ~(out_valid & id_stall));
  // Redirect target goes straight to the memory so the new path has no bubble.
  assign imem_addr = redirect_valid ? redirect_pc : pc_q;

  // Park the in-flight word only if the hold slot is free; once parked, issue
  // is blocked so the slot and the in-flight request never overlap.
  assign hold_capture = req_valid_q & id_stall & ~hold_valid & ~redirect_valid;
  assign hold_clear   = ~id_stall | redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      req_pc_q    <= redirect_pc;
      req_valid_q <= 1'b1;
      pc_q        <= redirect_pc + ADDR_W'(1);
    end else if (issue) begin
      req_pc_q    <= pc_q;
      req_valid_q <= 1'b1;
      pc_q        <= pc_q + ADDR_W'(1);
    end else begin
      req_valid_q <= 1'b0;
    end
  end

  fetch_hold_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .capture  (hold_capture),
    .clear    (hold_clear),
    .instr_in (imem_rdata),
    .pc_in    (req_pc_q),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );

  // The wrong-path instruction is squashed in the cycle the redirect arrives.
  always_comb begin
    if_valid = out_valid & ~redirect_valid;
    if_instr = DATA_W'(NOP_INSTR);
    if_pc    = '0;
    if (if_valid) begin
      if (hold_valid) begin
        if_instr = hold_instr;
        if_pc    = hold_pc;
      end else begin
        if_instr = imem_rdata;
        if_pc    = req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // Instruction memory: preloaded mem[i] = i + 100, 1-cycle synchronous read.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'(i) + 32'd100;
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic        rst, fe, st, rv;
    logic [9:0]  rpc;
    logic        ev;
    logic [9:0]  epc;
    logic [9:0]  ea;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [9:0]  epc;
    logic [31:0] ei;
    logic [9:0]  ea;
    string       nm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic fe, logic st, logic rv, logic [9:0] rpc,
                              logic ev, logic [9:0] epc, logic [9:0] ea);
    vec_t v;
    v.rst = rst; v.fe = fe; v.st = st; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got=%0d expected=%0d", nm, fld, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the edge, queue the expectation, and
  // compare mid-cycle against the popped entry.
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = v.rst;
    fetch_en       = v.fe;
    id_stall       = v.st;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    e.ev  = v.ev;
    e.epc = v.ev ? v.epc : 10'd0;
    e.ei  = v.ev ? (32'(v.epc) + 32'd100) : 32'd0;
    e.ea  = v.ea;
    e.nm  = nm;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.nm, "if_valid",  32'(if_valid),  32'(e.ev));
    chk(e.nm, "if_pc",     32'(if_pc),     32'(e.epc));
    chk(e.nm, "if_instr",  if_instr,       e.ei);
    chk(e.nm, "imem_addr", 32'(imem_addr), 32'(e.ea));
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; id_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    apply(mk(1,0,0,0,0, 0,0,0), "reset_state");

    // rst fe st rv rpc | ev epc ea
    tbl.push_back(mk(0,1,0,0,0,    0,0,0));      // first issue
    tbl.push_back(mk(0,1,0,0,0,    1,0,1));
    tbl.push_back(mk(0,1,0,0,0,    1,1,2));
    tbl.push_back(mk(0,1,0,0,0,    1,2,3));
    tbl.push_back(mk(0,1,0,0,0,    1,3,4));
    tbl.push_back(mk(0,1,1,0,0,    1,4,5));      // stall x3 at pc 4
    tbl.push_back(mk(0,1,1,0,0,    1,4,5));
    tbl.push_back(mk(0,1,1,0,0,    1,4,5));
    tbl.push_back(mk(0,1,0,0,0,    1,4,5));      // release
    tbl.push_back(mk(0,1,0,0,0,    1,5,6));
    tbl.push_back(mk(0,1,0,0,0,    1,6,7));
    tbl.push_back(mk(0,1,0,0,0,    1,7,8));
    tbl.push_back(mk(0,1,0,0,0,    1,8,9));
    tbl.push_back(mk(0,1,0,1,700,  0,0,700));    // pc 9 squashed
    tbl.push_back(mk(0,1,0,0,0,    1,700,701));
    tbl.push_back(mk(0,1,0,0,0,    1,701,702));
    tbl.push_back(mk(0,1,0,1,1022, 0,0,1022));   // wrap
    tbl.push_back(mk(0,1,0,0,0,    1,1022,1023));
    tbl.push_back(mk(0,1,0,0,0,    1,1023,0));
    tbl.push_back(mk(0,1,0,0,0,    1,0,1));
    tbl.push_back(mk(0,1,0,0,0,    1,1,2));
    tbl.push_back(mk(0,1,0,0,0,    1,2,3));
    tbl.push_back(mk(0,1,1,0,0,    1,3,4));      // hold 3
    tbl.push_back(mk(0,1,1,0,0,    1,3,4));
    tbl.push_back(mk(0,1,1,1,20,   0,0,20));     // redirect flushes hold
    tbl.push_back(mk(0,1,0,0,0,    1,20,21));
    tbl.push_back(mk(0,1,0,0,0,    1,21,22));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset pulse while pc 6 is on the output.
    apply(mk(0,1,0,1,5,   0,0,5),   "rst_redir5");
    apply(mk(0,1,0,0,0,   1,5,6),   "rst_pc5");
    apply(mk(1,1,0,0,0,   1,6,7),   "rst_pulse");
    apply(mk(0,1,0,0,0,   0,0,0),   "rst_after");
    apply(mk(0,1,0,0,0,   1,0,1),   "rst_restart0");
    apply(mk(0,1,0,0,0,   1,1,2),   "rst_restart1");

    // fetch_en low: in-flight completes, then nothing; pc frozen.
    apply(mk(0,0,0,0,0,   1,2,3),   "fe0_inflight");
    apply(mk(0,0,0,0,0,   0,0,3),   "fe0_idle1");
    apply(mk(0,0,0,0,0,   0,0,3),   "fe0_idle2");
    apply(mk(0,1,0,0,0,   0,0,3),   "fe1_issue");

    // Held instruction survives fetch_en low until consumed.
    apply(mk(0,1,1,0,0,   1,3,4),   "hold_stall");
    apply(mk(0,0,1,0,0,   1,3,4),   "hold_fe0");
    apply(mk(0,0,0,0,0,   1,3,4),   "hold_consume");
    apply(mk(0,0,0,0,0,   0,0,4),   "hold_empty");
    // Stall with nothing valid does not block issue.
    apply(mk(0,1,1,0,0,   0,0,4),   "stall_novalid");
    apply(mk(0,1,0,0,0,   1,4,5),   "stall_novalid_out");

    // Reset beats a simultaneous redirect.
    apply(mk(1,1,0,1,300, 0,0,300), "rst_and_redir");
    apply(mk(0,1,0,0,0,   0,0,0),   "rst_wins");
    apply(mk(0,1,0,0,0,   1,0,1),   "rst_wins_pc0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
